dpram_arbiter: RTL

Round-robin arbiter that shares the 64x8 `dual_port_ram` between NREQ independent requesters. Each cycle it grants up to two requests: the first winner goes to RAM port A, the second to port B. It blocks same-address hazards between the two ports and routes registered read data back to the requester that issued the read. The block sits directly in front of `dual_port_ram` and drives all of its port-side inputs.

---
 rtl/dpram_pkg.sv | 11 +
 rtl/dpram_arbiter_if.sv | 33 +++
 rtl/dpram_arbiter_rr_pick.sv | 22 ++
 rtl/dpram_arbiter.sv | 75 +++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// dpram_pkg: shared widths, RAM depth and per-port read tag for the dual-port RAM arbiter.
package dpram_pkg;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 6;
  localparam int DEPTH = 2 ** AW_DEF;
  localparam int IW = 3;
  typedef struct packed {
    logic valid;
    logic [IW-1:0] index;
  } port_tag_t;
endpackage

// File: rtl/dpram_arbiter_if.sv
// dpram_arbiter_if: requester-side and RAM-side bus of the arbiter.
interface dpram_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int AW = 6
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr_a;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_data_a;
  logic [DW-1:0] ram_data_b;
  logic ram_we_a;
  logic ram_we_b;
  logic [DW-1:0] ram_q_a;
  logic [DW-1:0] ram_q_b;
  logic [15:0] conflict_cnt;
  modport master (
    output req, req_we, req_addr, req_wdata, ram_q_a, ram_q_b,
    input gnt, rvalid, rdata, ram_addr_a, ram_addr_b, ram_data_a, ram_data_b,
    ram_we_a, ram_we_b, conflict_cnt
  );
  modport slave (
    input req, req_we, req_addr, req_wdata, ram_q_a, ram_q_b,
    output gnt, rvalid, rdata, ram_addr_a, ram_addr_b, ram_data_a, ram_data_b,
    ram_we_a, ram_we_b, conflict_cnt
  );
endinterface

// File: rtl/dpram_arbiter_rr_pick.sv
// rr_pick: first set bit of mask scanning start, start+1, ... modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] start,
  output logic          found,
  output logic [PW-1:0] idx
);
  // Walk the rotation backwards so the earliest hit overwrites later ones.
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[(int'(start) + k) % N]) begin
        found = 1'b1;
        idx = PW'((int'(start) + k) % N);
      end
    end
  end
endmodule

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: round-robin two-port arbiter in front of a dual-port RAM with
// hazard blocking, single-read-per-cycle rule and tagged read return.
module dpram_arbiter
  import dpram_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input logic clk,
  input logic rst_n,
  dpram_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0] ptr, idx_a, idx_b, start_b, ptr_nxt;
  logic found_a, found_b, go_a, go_b, a_we, b_we, deferred;
  logic [AW-1:0] a_addr;
  logic [NREQ-1:0] haz, oh_a, oh_b, mask_b;
  logic [15:0] cnt;
  port_tag_t tag_a, tag_b;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick_a (.mask(bus.req), .start(ptr), .found(found_a), .idx(idx_a));
  rr_pick #(.N(NREQ), .PW(PW)) u_pick_b (.mask(mask_b), .start(start_b), .found(found_b), .idx(idx_b));

  assign a_addr = bus.req_addr[int'(idx_a)*AW +: AW];
  assign a_we = bus.req_we[idx_a];
  assign b_we = bus.req_we[idx_b];
  assign start_b = (idx_a == PW'(NREQ - 1)) ? '0 : idx_a + 1'b1;
  assign ptr_nxt = found_b ? ((idx_b == PW'(NREQ - 1)) ? '0 : idx_b + 1'b1) : start_b;
  assign oh_a = found_a ? (NREQ'(1) << idx_a) : '0;
  assign oh_b = found_b ? (NREQ'(1) << idx_b) : '0;

  // Two reads can never share a cycle because there is only one rdata bus.
  always_comb begin
    haz = '0;
    for (int j = 0; j < NREQ; j++)
      haz[j] = (bus.req_addr[j*AW +: AW] == a_addr && (bus.req_we[j] || a_we)) ||
               (!bus.req_we[j] && !a_we);
  end

  assign mask_b = bus.req & ~oh_a & ~haz;
  assign deferred = found_a && |(bus.req & ~oh_a & haz);
  assign go_a = rst_n && found_a;
  assign go_b = rst_n && found_b;

  assign bus.gnt = (go_a ? oh_a : '0) | (go_b ? oh_b : '0);
  assign bus.ram_addr_a = go_a ? a_addr : '0;
  assign bus.ram_data_a = go_a ? bus.req_wdata[int'(idx_a)*DW +: DW] : '0;
  assign bus.ram_we_a = go_a && a_we;
  assign bus.ram_addr_b = go_b ? bus.req_addr[int'(idx_b)*AW +: AW] : '0;
  assign bus.ram_data_b = go_b ? bus.req_wdata[int'(idx_b)*DW +: DW] : '0;
  assign bus.ram_we_b = go_b && b_we;
  assign bus.rdata = tag_a.valid ? bus.ram_q_a : bus.ram_q_b;
  assign bus.conflict_cnt = cnt;

  always_comb begin
    bus.rvalid = '0;
    for (int i = 0; i < NREQ; i++)
      bus.rvalid[i] = (tag_a.valid && tag_a.index == IW'(i)) || (tag_b.valid && tag_b.index == IW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      tag_a <= '0;
      tag_b <= '0;
      cnt <= '0;
    end else begin
      if (found_a) ptr <= ptr_nxt;
      tag_a <= '{valid: found_a && !a_we, index: IW'(idx_a)};
      tag_b <= '{valid: found_b && !b_we, index: IW'(idx_b)};
      if (deferred && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
  end
endmodule
